// File: rtl/syndrome_stream_packer_pkg.sv
// syndrome_stream_packer_pkg: frame constants, FSM encodings and size helpers shared with the decoder-side parser.
package syndrome_stream_packer_pkg;
  localparam logic [7:0] START_BYTE_DEF = 8'h01;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HEADER = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_PAD    = 3'd4;
  function automatic int calc_m(input int x, input int z);
    return x * z;
  endfunction
  function automatic int calc_bpr(input int m);
    return (m + 7) / 8;
  endfunction
endpackage

// File: rtl/syndrome_stream_packer_if.sv
// syndrome_stream_packer_if: round input stream and byte output stream of the packer.
interface syndrome_stream_packer_if #(parameter int M = 4);
  logic [M-1:0] round_data;
  logic         round_valid;
  logic         round_ready;
  logic         round_last;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  modport slave (
    input  round_data, round_valid, round_last, out_ready,
    output round_ready, out_data, out_valid
  );
  modport master (
    output round_data, round_valid, round_last, out_ready,
    input  round_ready, out_data, out_valid
  );
endinterface

// File: rtl/syndrome_stream_packer.sv
// syndrome_stream_packer: frames measurement rounds into a header + LSB-first byte stream for the decoder.
module syndrome_stream_packer
  import syndrome_stream_packer_pkg::*;
#(
  parameter int         GRID_WIDTH_X = 4,
  parameter int         GRID_WIDTH_Z = 1,
  parameter int         GRID_WIDTH_U = 3,
  parameter logic [7:0] START_BYTE   = START_BYTE_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  syndrome_stream_packer_if.slave  bus,
  output logic                     frame_error,
  output logic [7:0]               frames_sent
);
  localparam int M   = calc_m(GRID_WIDTH_X, GRID_WIDTH_Z);
  localparam int BPR = calc_bpr(M);
  localparam int BW  = BPR * 8;
  localparam int RW  = (GRID_WIDTH_U > 1) ? $clog2(GRID_WIDTH_U) : 1;
  localparam int BCW = (BPR > 1) ? $clog2(BPR) : 1;
  localparam logic [RW-1:0]  LAST_ROUND = RW'(GRID_WIDTH_U - 1);
  localparam logic [BCW-1:0] LAST_BYTE  = BCW'(BPR - 1);

  logic [2:0]     state_q, state_d;
  logic [BW-1:0]  buf_q, buf_d;
  logic           last_q, last_d;
  logic [RW-1:0]  rc_q, rc_d;
  logic [BCW-1:0] bc_q, bc_d;
  logic           err_q, err_d;
  logic [7:0]     fs_q, fs_d;
  logic [7:0]     out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic           hs, acc, last_byte, last_round;

  function automatic logic [7:0] byte_mux(input logic [BW-1:0] b, input logic [BCW-1:0] i);
    return b[int'(i)*8 +: 8];
  endfunction

  assign bus.round_ready = (state_q == ST_IDLE) || (state_q == ST_WAIT);
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign frame_error     = err_q;
  assign frames_sent     = fs_q;
  assign hs              = out_valid_q && bus.out_ready;
  assign acc             = bus.round_valid && bus.round_ready;
  assign last_byte       = bc_q == LAST_BYTE;
  assign last_round      = rc_q == LAST_ROUND;

  // PAD reuses round/byte counters so it emits exactly the bytes of the rounds still owed.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    last_d  = last_q;
    rc_d    = rc_q;
    bc_d    = bc_q;
    err_d   = err_q;
    fs_d    = fs_q;
    case (state_q)
      ST_IDLE: if (acc) begin
        buf_d   = BW'(bus.round_data);
        last_d  = bus.round_last;
        rc_d    = '0;
        bc_d    = '0;
        state_d = ST_HEADER;
      end
      ST_HEADER: if (hs) begin
        bc_d    = '0;
        state_d = ST_DATA;
      end
      ST_DATA: if (hs) begin
        if (!last_byte) bc_d = bc_q + 1'b1;
        else if (last_round) begin
          fs_d    = fs_q + 8'd1;
          err_d   = err_q | ~last_q;
          state_d = ST_IDLE;
        end else if (last_q) begin
          err_d   = 1'b1;
          buf_d   = '0;
          rc_d    = rc_q + 1'b1;
          bc_d    = '0;
          state_d = ST_PAD;
        end else state_d = ST_WAIT;
      end
      ST_WAIT: if (acc) begin
        buf_d   = BW'(bus.round_data);
        last_d  = bus.round_last;
        rc_d    = rc_q + 1'b1;
        bc_d    = '0;
        state_d = ST_DATA;
      end
      ST_PAD: if (hs) begin
        if (!last_byte) bc_d = bc_q + 1'b1;
        else if (last_round) begin
          fs_d    = fs_q + 8'd1;
          state_d = ST_IDLE;
        end else begin
          rc_d = rc_q + 1'b1;
          bc_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    out_valid_d = (state_d == ST_HEADER) || (state_d == ST_DATA) || (state_d == ST_PAD);
    out_data_d  = (state_d == ST_HEADER) ? START_BYTE :
                  (state_d == ST_DATA)   ? byte_mux(buf_d, bc_d) : 8'h00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      last_q      <= 1'b0;
      rc_q        <= '0;
      bc_q        <= '0;
      err_q       <= 1'b0;
      fs_q        <= 8'd0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      last_q      <= last_d;
      rc_q        <= rc_d;
      bc_q        <= bc_d;
      err_q       <= err_d;
      fs_q        <= fs_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_syndrome_stream_packer.sv
// tb_syndrome_stream_packer: random and directed frames checked against a queue-based frame model.
module tb_syndrome_stream_packer;
  localparam int U = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_error;
  logic [7:0] frames_sent;

  syndrome_stream_packer_if #(.M(4)) bus();

  syndrome_stream_packer #(
    .GRID_WIDTH_X(4), .GRID_WIDTH_Z(1), .GRID_WIDTH_U(U), .START_BYTE(8'h01)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .frame_error(frame_error), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         mode  = 0;
  int         cyc   = 0;
  int         hs_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  int         hs_cyc[$];
  int         m_round = 0;
  bit         m_err = 0;
  logic [7:0] m_frames = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired, got timeout, expected completion", nm);
  endtask

  // Frame model: header on the first round, data bytes, zero padding after an early last.
  task automatic m_accept(input logic [3:0] d, input bit last);
    if (m_round == 0) exp_q.push_back(8'h01);
    exp_q.push_back({4'h0, d});
    if (m_round == U - 1) begin
      if (!last) m_err = 1;
      m_frames++;
      m_round = 0;
    end else if (last) begin
      for (int i = 0; i < U - 1 - m_round; i++) exp_q.push_back(8'h00);
      m_err = 1;
      m_frames++;
      m_round = 0;
    end else m_round++;
  endtask

  task automatic send_round(input logic [3:0] d, input bit last);
    int t = 0;
    bus.round_data  = d;
    bus.round_last  = last;
    bus.round_valid = 1'b1;
    while (!bus.round_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail_now("round_accept");
    else begin
      m_accept(d, last);
      @(negedge clk);
    end
    bus.round_valid = 1'b0;
  endtask

  task automatic assert_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_round_ready", bus.round_ready, 1);
    chk("rst_frame_error", frame_error, 0);
    chk("rst_frames_sent", frames_sent, 0);
    exp_q.delete();
    cap_q.delete();
    hs_cyc.delete();
    m_round = 0;
    m_err = 0;
    m_frames = 0;
    bus.round_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    assert_reset();
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) fail_now("drain");
    chk("model_frames_sent", frames_sent, m_frames);
    chk("model_frame_error", frame_error, m_err);
    chk("model_leftover", exp_q.size(), 0);
  endtask

  function automatic logic [31:0] cap4();
    return {cap_q[0], cap_q[1], cap_q[2], cap_q[3]};
  endfunction

  initial begin
    int k = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: bus.out_ready = 1'b1;
        1: begin bus.out_ready = (k % 3 == 0); k++; end
        2: bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    logic       pv, pr;
    logic [7:0] pd;
    pv = 0; pr = 0; pd = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        chk("ready_vs_valid", bus.round_ready, !bus.out_valid);
        if (pv && !pr) begin
          chk("stall_valid", bus.out_valid, 1);
          chk("stall_data", bus.out_data, pd);
        end
        if (bus.out_valid && bus.out_ready) begin
          cap_q.push_back(bus.out_data);
          hs_cyc.push_back(cyc);
          hs_cnt++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte: got %0h, expected no byte", bus.out_data);
          end else chk("byte", bus.out_data, exp_q.pop_front());
        end
        pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data;
      end else begin
        pv = 0; pr = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t;
    bus.round_data = '0;
    bus.round_valid = 1'b0;
    bus.round_last = 1'b0;
    assert_reset();

    mode = 0;
    send_round(4'b1010, 0);
    chk("t1_header_next_cycle_valid", bus.out_valid, 1);
    chk("t1_header_next_cycle_data", bus.out_data, 8'h01);
    send_round(4'b0001, 0);
    send_round(4'b1111, 1);
    drain();
    chk("t1_count", cap_q.size(), 4);
    chk("t1_bytes", cap4(), 32'h010A010F);
    chk("t1_frames", frames_sent, 1);
    chk("t1_error", frame_error, 0);
    chk("t1_gap_data0", hs_cyc[1] - hs_cyc[0], 1);
    chk("t1_gap_round2", hs_cyc[2] - hs_cyc[1], 2);
    chk("t1_gap_round3", hs_cyc[3] - hs_cyc[2], 2);

    do_reset();
    mode = 1;
    send_round(4'b1010, 0);
    send_round(4'b0001, 0);
    send_round(4'b1111, 1);
    drain();
    chk("t2_bytes", cap4(), 32'h010A010F);
    chk("t2_frames", frames_sent, 1);

    do_reset();
    send_round(4'h3, 0);
    send_round(4'h5, 1);
    drain();
    chk("t3_count", cap_q.size(), 4);
    chk("t3_bytes", cap4(), 32'h01030500);
    chk("t3_error", frame_error, 1);
    chk("t3_frames", frames_sent, 1);

    do_reset();
    mode = 0;
    send_round(4'h1, 0);
    send_round(4'h2, 0);
    send_round(4'h3, 0);
    drain();
    chk("t4_count", cap_q.size(), 4);
    chk("t4_bytes", cap4(), 32'h01010203);
    chk("t4_error", frame_error, 1);

    do_reset();
    base = hs_cnt;
    send_round(4'hC, 0);
    t = 0;
    while (hs_cnt < base + 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail_now("t5_two_bytes");
    mode = 3;
    send_round(4'hD, 0);
    chk("t5_valid_before_reset", bus.out_valid, 1);
    assert_reset();
    mode = 0;
    send_round(4'h7, 0);
    send_round(4'h0, 0);
    send_round(4'h9, 1);
    drain();
    chk("t5_bytes", cap4(), 32'h01070009);
    chk("t5_frames", frames_sent, 1);

    do_reset();
    mode = 2;
    for (int f = 0; f < 256; f++)
      for (int r = 0; r < U; r++) send_round(4'($urandom_range(0, 15)), r == U - 1);
    drain();
    chk("t6_frames_wrap", frames_sent, 0);
    chk("t6_error", frame_error, 0);

    for (int r = 0; r < 60; r++) send_round(4'($urandom_range(0, 15)), $urandom_range(0, 2) == 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/syndrome_stream_packer.md
# syndrome_stream_packer

Packs per-round stabilizer measurement vectors into the 8-bit valid/ready byte stream consumed by the single-FPGA decoder input port (`input_data`/`input_valid`/`input_ready`). Each frame is one start byte followed by GRID_WIDTH_U rounds of measurement bytes, LSB first. It sits directly upstream of the decoder's unified controller. It flags rounds whose `round_last` marker disagrees with GRID_WIDTH_U.

## Interface
- GRID_WIDTH_X, default 4: stabilizer columns.
- GRID_WIDTH_Z, default 1: stabilizer rows.
- GRID_WIDTH_U, default 3: measurement rounds per frame.
- START_BYTE, default 8'h01: frame header byte.
- Derived: M = GRID_WIDTH_X*GRID_WIDTH_Z; BPR = ceil(M/8) bytes per round.
- `clk` input 1: single clock; all state on rising edge.
- `reset` input 1: asynchronous, active-low.
- `round_data` input M: one round of measurements; bit i is PU i of that round.
- `round_valid` input 1: round_data valid.
- `round_ready` output 1: round accepted when valid&&ready.
- `round_last` input 1: producer marks the final round of a frame; sampled with round_data.
- `out_data` output 8: byte to the decoder input_data.
- `out_valid` output 1: to the decoder input_valid.
- `out_ready` input 1: from the decoder input_ready.
- `frame_error` output 1: sticky; set on round_last mismatch.
- `frames_sent` output 8: count of completed frames; wraps 255->0.

## Operation
- States: IDLE, HEADER, DATA, WAIT, PAD.
- IDLE:
  - round_ready=1, out_valid=0.
  - Round accept: latch round_data, zero-extended to BPR*8 bits, into the shift buffer; round_cnt=0 -> HEADER.
- HEADER:
  - out_valid=1, out_data=START_BYTE.
  - On handshake: byte_cnt=0 -> DATA.
- DATA:
  - out_valid=1, out_data=buffer[byte_cnt*8 +: 8].
  - Handshake, byte_cnt<BPR-1: byte_cnt++.
  - Handshake on the last byte, next state:
    - round_cnt==U-1: frames_sent++ -> IDLE.
    - Latched last flag set (early last): frame_error<=1 -> PAD.
    - Otherwise -> WAIT.
- WAIT:
  - round_ready=1, out_valid=0.
  - Round accept: latch data and last flag; round_cnt++, byte_cnt=0 -> DATA.
- PAD:
  - out_valid=1, out_data=8'h00.
  - Emits (U-1-round_cnt)*BPR zero bytes, then frames_sent++ -> IDLE.
  - round_ready=0 throughout.
- Missing last: round_last==0 on round U-1 sets frame_error; the frame closes normally.
- frame_error clears only on reset.
- round_ready is combinational from state; it never depends on round_valid.
- out_data, out_valid and the buffer are registered. No combinational path exists from out_ready to out_data or out_valid.

## Timing
- Reset values: state IDLE, out_valid=0, out_data=8'h00, round_ready=1, frame_error=0, frames_sent=0, counters 0.
- Reset mid-frame discards the partial frame. The next accepted round starts a fresh frame with a header.
- Accept in IDLE at cycle t: header valid at t+1.
- With out_ready held high, a frame occupies the output for 1+U*BPR beats. There is one bubble cycle (WAIT, out_valid=0) before each round after the first.
- While out_valid&&!out_ready, out_data is held stable.
- out_valid never drops without a handshake, except on reset.
- A round offered in any state other than IDLE or WAIT is back-pressured (round_ready=0).

## Structure
- Shared package: START_BYTE default, state enum, and the BPR/M derivation functions. The decoder-side input parser imports the same definitions.
- No sub-module needed. Optional: one `byte_mux` function selecting buffer bytes.

## Test plan
Defaults for all cases: X=4, Z=1, U=3, so M=4, BPR=1.
1. Reset, then three rounds 4'b1010, 4'b0001, 4'b1111 (last on the third), out_ready=1 -> bytes 01,0A,01,0F; frames_sent=1; frame_error=0; one bubble before each of rounds 2 and 3.
2. Same stimulus with out_ready toggling 1,0,0,1,... -> identical byte sequence; out_data stable across every stall cycle.
3. round_last on round 2 of 3, data 4'h3 then 4'h5 -> bytes 01,03,05,00; frame_error=1; frames_sent=1; round_ready=0 during PAD.
4. No round_last on the third round -> 4 bytes emitted; frame_error=1.
5. Reset deasserted-to-asserted after the header and one data byte -> out_valid=0 immediately. Next frame 4'h7,4'h0,4'h9 -> 01,07,00,09.
6. 256 back-to-back frames -> frames_sent wraps to 0; frame_error stays 0.
